// File: rtl/i2c_mem_target.sv
// I2C target fronting a byte-wide memory with an auto-incrementing word pointer.
// Define I2C_TGT_WP_EN to add a WP input that blocks data-byte writes while high.
module i2c_mem_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          SCL,
  inout  wire           SDA,
`ifdef I2C_TGT_WP_EN
  input  logic          WP,
`endif
  output logic          Busy,
  output logic          Wr_valid,
  output logic [AW-1:0] Wr_addr,
  output logic [7:0]    Wr_data,
  output logic [AW-1:0] Rd_ptr
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEV_ADDR  = 4'd1,
    S_DEV_ACK   = 4'd2,
    S_WORD_ADDR = 4'd3,
    S_WA_ACK    = 4'd4,
    S_WR_DATA   = 4'd5,
    S_WR_ACK    = 4'd6,
    S_RD_DATA   = 4'd7,
    S_RD_MACK   = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic            scl_s1_q, scl_s2_q, scl_d1_q;
  logic            sda_s1_q, sda_s2_q, sda_d1_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_valid_q, wr_valid_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      mem_q [DEPTH];

  logic            scl_rise_s, scl_fall_s, start_s, stop_s;
  logic            mem_we_s, load_rd_s, wp_s;
  logic [7:0]      byte_s, rd_byte_s;

`ifdef I2C_TGT_WP_EN
  assign wp_s = WP;
`else
  assign wp_s = 1'b0;
`endif

  assign scl_rise_s = scl_s2_q & ~scl_d1_q;
  assign scl_fall_s = ~scl_s2_q & scl_d1_q;
  assign start_s    = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
  assign stop_s     = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;
  assign byte_s     = {shift_q[6:0], sda_s2_q};
  assign rd_byte_s  = mem_q[rd_ptr_q];

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign Busy     = busy_q;
  assign Wr_valid = wr_valid_q;
  assign Wr_addr  = wr_addr_q;
  assign Wr_data  = wr_data_q;
  assign Rd_ptr   = rd_ptr_q;

  // Next-state logic: bus conditions first, then sampling on SCL rise, drive updates on SCL fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    rd_ptr_d   = rd_ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we_s   = 1'b0;
    load_rd_s  = 1'b0;
    if (stop_s) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_s) begin
      state_d   = S_DEV_ADDR;
      bit_cnt_d = 3'd7;
      sda_oe_d  = 1'b0;
    end else if (scl_rise_s) begin
      case (state_q)
        S_DEV_ADDR: begin
          shift_d = byte_s;
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (shift_q[6:0] == DEV_ADDR) begin
            state_d = S_DEV_ACK;
            rw_d    = sda_s2_q;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
        S_WORD_ADDR: begin
          shift_d = byte_s;
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            rd_ptr_d = byte_s[AW-1:0];
            state_d  = S_WA_ACK;
          end
        end
        S_WR_DATA: begin
          shift_d = byte_s;
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            mem_we_s   = ~wp_s;
            wr_valid_d = ~wp_s;
            if (!wp_s) begin
              wr_addr_d = rd_ptr_q;
              wr_data_d = byte_s;
            end else begin
              wr_addr_d = wr_addr_q;
              wr_data_d = wr_data_q;
            end
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = S_WR_ACK;
          end
        end
        S_RD_MACK: begin
          if (sda_s2_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RD_MACK;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (scl_fall_s) begin
      case (state_q)
        // First fall in an ACK state starts the ACK pulse, the second ends it.
        S_DEV_ACK, S_WA_ACK, S_WR_ACK: begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if ((state_q == S_DEV_ACK) && rw_q) begin
            load_rd_s = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = (state_q == S_DEV_ACK) ? S_WORD_ADDR : S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (bit_cnt_q != 3'd0) begin
            shift_d   = {shift_q[6:0], 1'b1};
            sda_oe_d  = ~shift_q[7];
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = S_RD_MACK;
          end
        end
        S_RD_MACK: begin
          load_rd_s = 1'b1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    // Shift register holds the not-yet-driven bits so the MSB is always the next one out.
    if (load_rd_s) begin
      shift_d   = {rd_byte_s[6:0], 1'b1};
      sda_oe_d  = ~rd_byte_s[7];
      bit_cnt_d = 3'd7;
      rd_ptr_d  = rd_ptr_q + AW'(1);
      state_d   = S_RD_DATA;
    end else begin
      state_d = state_d;
    end
  end

  // Synchronizers, edge-detect history, FSM and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_d1_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      rd_ptr_q   <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      scl_s1_q   <= SCL;
      scl_s2_q   <= scl_s1_q;
      scl_d1_q   <= scl_s2_q;
      sda_s1_q   <= SDA;
      sda_s2_q   <= sda_s1_q;
      sda_d1_q   <= sda_s2_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      rd_ptr_q   <= rd_ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !Reset) begin
      mem_q[rd_ptr_q] <= byte_s;
    end
  end

endmodule

// File: tb/tb_i2c_mem_target.sv
// Directed bench for i2c_mem_target: bit-banged initiator on a pulled-up SDA line.
module tb_i2c_mem_target;
  localparam int QTR = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_low;
  logic       wp;
  wire        sda_bus;
  logic       busy, wr_valid;
  logic [7:0] wr_addr, wr_data, rd_ptr;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] wq_addr [$];
  logic [7:0] wq_data [$];
  logic       ack_n;
  logic       b;
  logic [7:0] rd;

  always #5 clk = ~clk;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_mem_target dut (
    .clk      (clk),
    .Reset    (rst),
    .SCL      (scl_m),
    .SDA      (sda_bus),
`ifdef I2C_TGT_WP_EN
    .WP       (wp),
`endif
    .Busy     (busy),
    .Wr_valid (wr_valid),
    .Wr_addr  (wr_addr),
    .Wr_data  (wr_data),
    .Rd_ptr   (rd_ptr)
  );

  // Record every committed write.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic qwait(input int n);
    repeat (n * QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; qwait(1);
    scl_m = 1'b1;   qwait(1);
    sda_low = 1'b1; qwait(1);
    scl_m = 1'b0;   qwait(1);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; qwait(1);
    scl_m = 1'b1;   qwait(1);
    sda_low = 1'b0; qwait(1);
  endtask

  task automatic write_bit(input logic v);
    sda_low = ~v; qwait(1);
    scl_m = 1'b1; qwait(2);
    scl_m = 1'b0; qwait(1);
  endtask

  task automatic read_bit(output logic v);
    sda_low = 1'b0; qwait(1);
    scl_m = 1'b1;   qwait(1);
    v = sda_bus;    qwait(1);
    scl_m = 1'b0;   qwait(1);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic an);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(an);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  task automatic clear_wq();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_low = 1'b0; wp = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_sda", sda_bus, 1);
    rst = 1'b0;
    qwait(2);

    // Write 0x5A, 0xC3 starting at 0x10
    clear_wq();
    i2c_start();
    write_byte(8'hA0, ack_n); check("wr_dev_ack", ack_n, 0);
    write_byte(8'h10, ack_n); check("wr_wa_ack", ack_n, 0);
    check("wr_busy", busy, 1);
    write_byte(8'h5A, ack_n); check("wr_d0_ack", ack_n, 0);
    write_byte(8'hC3, ack_n); check("wr_d1_ack", ack_n, 0);
    i2c_stop();
    qwait(1);
    check("wr_count", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      check("wr0_addr", wq_addr[0], 8'h10); check("wr0_data", wq_data[0], 8'h5A);
      check("wr1_addr", wq_addr[1], 8'h11); check("wr1_data", wq_data[1], 8'hC3);
    end
    check("wr_rd_ptr", rd_ptr, 8'h12);
    check("wr_busy_after_stop", busy, 0);

    // Random read from 0x10 with repeated START
    clear_wq();
    i2c_start();
    write_byte(8'hA0, ack_n); check("rr_dev_ack", ack_n, 0);
    write_byte(8'h10, ack_n); check("rr_wa_ack", ack_n, 0);
    i2c_start();
    write_byte(8'hA1, ack_n); check("rr_rdev_ack", ack_n, 0);
    read_byte(1'b0, rd); check("rr_byte0", rd, 8'h5A);
    read_byte(1'b1, rd); check("rr_byte1", rd, 8'hC3);
    check("rr_busy_after_nack", busy, 0);
    i2c_stop();
    check("rr_rd_ptr", rd_ptr, 8'h12);
    check("rr_no_write", wq_addr.size(), 0);

    // Address mismatch
    i2c_start();
    write_byte(8'hA2, ack_n); check("mm_nack", ack_n, 1);
    check("mm_busy", busy, 0);
    write_byte(8'h00, ack_n); check("mm_data_nack", ack_n, 1);
    i2c_stop();
    check("mm_no_write", wq_addr.size(), 0);
    check("mm_rd_ptr", rd_ptr, 8'h12);

    // Pointer wrap on write and read
    clear_wq();
    i2c_start();
    write_byte(8'hA0, ack_n);
    write_byte(8'hFF, ack_n);
    write_byte(8'h11, ack_n); check("wrap_d0_ack", ack_n, 0);
    write_byte(8'h22, ack_n); check("wrap_d1_ack", ack_n, 0);
    i2c_stop();
    qwait(1);
    check("wrap_count", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      check("wrap0_addr", wq_addr[0], 8'hFF); check("wrap0_data", wq_data[0], 8'h11);
      check("wrap1_addr", wq_addr[1], 8'h00); check("wrap1_data", wq_data[1], 8'h22);
    end
    check("wrap_rd_ptr", rd_ptr, 8'h01);
    i2c_start();
    write_byte(8'hA0, ack_n);
    write_byte(8'hFF, ack_n);
    i2c_start();
    write_byte(8'hA1, ack_n);
    read_byte(1'b0, rd); check("wrap_rd0", rd, 8'h11);
    read_byte(1'b1, rd); check("wrap_rd1", rd, 8'h22);
    i2c_stop();

    // Reset during bit 4 of a read of 0xC3 (bit 4 is a driven 0)
    i2c_start();
    write_byte(8'hA0, ack_n);
    write_byte(8'h11, ack_n);
    i2c_start();
    write_byte(8'hA1, ack_n);
    rd = 8'h00;
    read_bit(rd[7]); read_bit(rd[6]); read_bit(rd[5]);
    check("mr_first3", rd[7:5], 3'b110);
    sda_low = 1'b0; qwait(1);
    scl_m = 1'b1;   qwait(1);
    check("mr_sda_driven", sda_bus, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mr_sda_released", sda_bus, 1);
    check("mr_rd_ptr", rd_ptr, 0);
    check("mr_busy", busy, 0);
    rst = 1'b0;
    qwait(1);
    scl_m = 1'b0; qwait(1);
    i2c_stop();
    i2c_start();
    write_byte(8'hA1, ack_n); check("mr_dev_ack", ack_n, 0);
    read_byte(1'b1, rd); check("mr_mem0", rd, 8'h22);
    i2c_stop();
    check("mr_rd_ptr_after", rd_ptr, 8'h01);

`ifdef I2C_TGT_WP_EN
    // Write protect: seed 0x20, then a protected write must leave it intact
    i2c_start();
    write_byte(8'hA0, ack_n);
    write_byte(8'h20, ack_n);
    write_byte(8'h77, ack_n);
    i2c_stop();
    clear_wq();
    wp = 1'b1;
    i2c_start();
    write_byte(8'hA0, ack_n);
    write_byte(8'h20, ack_n); check("wp_wa_ack", ack_n, 0);
    write_byte(8'h99, ack_n); check("wp_data_ack", ack_n, 0);
    i2c_stop();
    check("wp_no_write", wq_addr.size(), 0);
    check("wp_rd_ptr", rd_ptr, 8'h21);
    wp = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack_n);
    write_byte(8'h20, ack_n);
    i2c_start();
    write_byte(8'hA1, ack_n);
    read_byte(1'b1, rd); check("wp_old_value", rd, 8'h77);
    i2c_stop();
`endif

    qwait(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
